// File: rtl/srlzr_pkg.sv
`default_nettype none
// ============================================================================
// Package  : srlzr_pkg
// Purpose  : Shared definitions for the serializer transmit controller:
//            FSM state encoding and a constant-width helper used to size
//            the bit divider and bit counter.
// Revision : 1.0 - initial release
// ============================================================================
package srlzr_pkg;

    // FSM state encoding (3 bits wide to hold all five states)
    typedef logic [2:0] srlzr_state_t;

    localparam srlzr_state_t ST_IDLE   = 3'd0;
    localparam srlzr_state_t ST_START  = 3'd1;
    localparam srlzr_state_t ST_DATA   = 3'd2;
    localparam srlzr_state_t ST_PARITY = 3'd3;
    localparam srlzr_state_t ST_STOP   = 3'd4;

    // Bits needed to hold the values 0..value-1; never less than 1 so that
    // counters sized from it always have a legal declaration.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_reg
// Purpose  : Parallel-in / serial-out shift register. The serial bit is q[0];
//            each shift moves the word one place toward bit 0, filling zeros.
// Ports    : clk   - system clock
//            rst   - synchronous active-high reset, clears q
//            load  - copy d into q (takes priority over shift)
//            shift - shift q right by one
//            d     - parallel word in
//            q     - register contents
// Revision : 1.0 - initial release
// ============================================================================
module piso_shift_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (shift) begin
            // Shift operator rather than a slice so a 1-bit word still works
            r_q <= r_q >> 1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/serializer_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serializer_tx_ctrl
// Purpose  : Frame controller for the PISO transmit path. Accepts a parallel
//            word over valid/ready, then drives start / data (LSB first) /
//            [parity] / stop bits onto tx_line, each bit CLK_DIV clocks long.
// Config   : SRLZR_PARITY_EN - when defined, a parity bit (even, or odd when
//            PARITY_ODD=1) is sent between the data and stop bits.
// Ports    : clk      - system clock
//            rst      - synchronous active-high reset (aborts a frame)
//            en       - transmitter enable, gates word acceptance only
//            in_data  - word to send
//            in_valid - in_data is valid
//            in_ready - controller can accept a word this cycle
//            tx_line  - serial output, idle high
//            busy     - frame in progress
//            done     - one-cycle pulse after the final stop bit
// Revision : 1.0 - initial release
// ============================================================================
module serializer_tx_ctrl
    import srlzr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx_line,
    output logic                  busy,
    output logic                  done
);

    localparam int c_DIV_W = clog2(CLK_DIV);
    localparam int c_BIT_W = clog2((DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    srlzr_state_t          r_state;
    srlzr_state_t          w_state_next;
    logic [c_DIV_W-1:0]    r_div_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic                  w_in_ready;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_bit_inc;
    logic                  w_tx;
    logic [DATA_WIDTH-1:0] w_sreg_q;

    // ------------------------------------------------------------------
    // Data shift register; q[0] is the bit currently on the line
    // ------------------------------------------------------------------
    piso_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sreg (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .d     (in_data),
        .q     (w_sreg_q)
    );

`ifdef SRLZR_PARITY_EN
    // Parity is computed from the word at load time so later changes on
    // in_data cannot affect the frame already in flight.
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= (^in_data) ^ (PARITY_ODD != 0);
        end
    end
`endif

    assign w_tick     = (r_div_cnt == c_DIV_LAST);
    assign w_in_ready = (r_state == ST_IDLE) && en && !rst;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_bit_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && w_in_ready) begin
                    w_load       = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == c_DATA_LAST) begin
`ifdef SRLZR_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
`ifdef SRLZR_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_STOP_LAST) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, divider, bit counter and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Every state entry starts a fresh bit period; IDLE holds it at 0
            if ((w_state_next != r_state) || (r_state == ST_IDLE) || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            // Counts data bits in DATA and stop bits in STOP
            if (w_state_next != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            r_busy <= (w_state_next != ST_IDLE);
            r_done <= (r_state == ST_STOP) && (w_state_next == ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Line level decoded from the registered state and shift register
    // ------------------------------------------------------------------
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            ST_START: w_tx = 1'b0;
            ST_DATA:  w_tx = w_sreg_q[0];
`ifdef SRLZR_PARITY_EN
            ST_PARITY: w_tx = r_parity;
`endif
            default:  w_tx = 1'b1;
        endcase
    end

    assign in_ready = w_in_ready;
    assign tx_line  = w_tx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serializer_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serializer_tx_ctrl
// Purpose  : Self-checking bench for serializer_tx_ctrl. Instance A uses one
//            stop bit, instance B two stop bits; both run with CLK_DIV=4.
//            Expected line levels are derived from the frame format directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serializer_tx_ctrl;

    localparam int DW   = 8;
    localparam int CD   = 4;
    localparam bit PODD = 1'b0;
`ifdef SRLZR_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LA = (1 + DW + P + 1) * CD;
    localparam int LB = (1 + DW + P + 2) * CD;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, in_valid, in_ready, tx_line, busy, done;
    logic [DW-1:0] in_data;
    logic          b_en, b_valid, b_ready, b_tx, b_busy, b_done;
    logic [DW-1:0] b_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serializer_tx_ctrl #(
        .DATA_WIDTH (DW), .CLK_DIV (CD), .STOP_BITS (1), .PARITY_ODD (int'(PODD))
    ) u_dut_a (
        .clk (clk), .rst (rst), .en (en), .in_data (in_data), .in_valid (in_valid),
        .in_ready (in_ready), .tx_line (tx_line), .busy (busy), .done (done)
    );

    serializer_tx_ctrl #(
        .DATA_WIDTH (DW), .CLK_DIV (CD), .STOP_BITS (2), .PARITY_ODD (int'(PODD))
    ) u_dut_b (
        .clk (clk), .rst (rst), .en (b_en), .in_data (b_data), .in_valid (b_valid),
        .in_ready (b_ready), .tx_line (b_tx), .busy (b_busy), .done (b_done)
    );

    // Line level expected i clocks after acceptance: bit period i/CD of the
    // frame start, data LSB first, optional parity, then stop level.
    function automatic logic exp_bit(input logic [DW-1:0] w, input int i);
        int b;
        b = i / CD;
        if (b == 0)                     return 1'b0;
        if (b <= DW)                    return w[b-1];
        if ((P == 1) && (b == DW + 1))  return (^w) ^ PODD;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0;
        b_en = 1'b1; b_valid = 1'b0; b_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({tx_line, busy, done, in_ready} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_a got=%b exp=1000", {tx_line, busy, done, in_ready});
        end
        n_checks++;
        if ({b_tx, b_busy, b_done, b_ready} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_b got=%b exp=1000", {b_tx, b_busy, b_done, b_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tx_line, busy, done, in_ready} !== 4'b1001) begin
            n_fail++; $display("FAIL idle_after_reset got=%b exp=1001", {tx_line, busy, done, in_ready});
        end
    endtask

    // A5, 07 and random words; in_data/in_valid are scrambled mid-frame
    task automatic test_single_frames();
        logic [DW-1:0] words[$];
        words = {8'hA5, 8'h07};
        repeat (5) words.push_back(DW'($urandom));
        foreach (words[n]) begin
            @(negedge clk);
            in_data = words[n]; in_valid = 1'b1;
            @(posedge clk); #1;
            for (int i = 0; i < LA; i++) begin
                in_data  = DW'($urandom);
                in_valid = (i < LA - 2) ? 1'($urandom) : 1'b0;
                @(negedge clk);
                n_checks++;
                if ({tx_line, busy, done, in_ready} !== {exp_bit(words[n], i), 3'b100}) begin
                    n_fail++;
                    $display("FAIL frame word=%h cyc=%0d got=%b exp=%b", words[n], i,
                             {tx_line, busy, done, in_ready}, {exp_bit(words[n], i), 3'b100});
                end
                @(posedge clk); #1;
            end
            @(negedge clk);
            n_checks++;
            if ({tx_line, busy, done, in_ready} !== 4'b1011) begin
                n_fail++; $display("FAIL done_cycle word=%h got=%b exp=1011", words[n], {tx_line, busy, done, in_ready});
            end
            @(negedge clk);
            n_checks++;
            if ({tx_line, busy, done, in_ready} !== 4'b1001) begin
                n_fail++; $display("FAIL done_width word=%h got=%b exp=1001", words[n], {tx_line, busy, done, in_ready});
            end
        end
    endtask

    // 00 then FF with in_valid held: second frame starts right after done
    task automatic test_back_to_back();
        logic [DW-1:0] w[2];
        w[0] = 8'h00; w[1] = 8'hFF;
        @(negedge clk);
        in_data = w[0]; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = w[1];
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < LA; i++) begin
                @(negedge clk);
                n_checks++;
                if ({tx_line, busy, done, in_ready} !== {exp_bit(w[f], i), 3'b100}) begin
                    n_fail++;
                    $display("FAIL b2b frame=%0d cyc=%0d got=%b exp=%b", f, i,
                             {tx_line, busy, done, in_ready}, {exp_bit(w[f], i), 3'b100});
                end
            end
            @(negedge clk);
            n_checks++;
            if ({tx_line, busy, done, in_ready} !== 4'b1011) begin
                n_fail++; $display("FAIL b2b_done frame=%0d got=%b exp=1011", f, {tx_line, busy, done, in_ready});
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({tx_line, busy, done, in_ready} !== 4'b1001) begin
            n_fail++; $display("FAIL b2b_idle got=%b exp=1001", {tx_line, busy, done, in_ready});
        end
    endtask

    task automatic test_two_stop_bits();
        logic [DW-1:0] w;
        w = 8'h3C;
        @(negedge clk);
        b_data = w; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        for (int i = 0; i < LB; i++) begin
            @(negedge clk);
            n_checks++;
            if ({b_tx, b_busy, b_done, b_ready} !== {exp_bit(w, i), 3'b100}) begin
                n_fail++;
                $display("FAIL stop2 cyc=%0d got=%b exp=%b", i, {b_tx, b_busy, b_done, b_ready}, {exp_bit(w, i), 3'b100});
            end
        end
        @(negedge clk);
        n_checks++;
        if ({b_tx, b_busy, b_done, b_ready} !== 4'b1011) begin
            n_fail++; $display("FAIL stop2_done got=%b exp=1011", {b_tx, b_busy, b_done, b_ready});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] w;
        int            bad;
        @(negedge clk);
        in_data = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_line, busy} !== {exp_bit(8'hA5, i), 1'b1}) begin
                n_fail++; $display("FAIL pre_abort cyc=%0d got=%b exp=%b", i, {tx_line, busy}, {exp_bit(8'hA5, i), 1'b1});
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tx_line, busy, done, in_ready} !== 4'b1000) begin
            n_fail++; $display("FAIL abort got=%b exp=1000", {tx_line, busy, done, in_ready});
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < LA; i++) begin
            @(negedge clk);
            if ({tx_line, busy, done} !== 3'b100) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL post_abort_quiet got=%0d bad cycles exp=0", bad);
        end
        w = DW'($urandom);
        in_data = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < LA; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_line, busy, done} !== {exp_bit(w, i), 2'b10}) begin
                n_fail++; $display("FAIL recover word=%h cyc=%0d got=%b exp=%b", w, i, {tx_line, busy, done}, {exp_bit(w, i), 2'b10});
            end
        end
        @(negedge clk);
        n_checks++;
        if ({tx_line, busy, done} !== 3'b101) begin
            n_fail++; $display("FAIL recover_done got=%b exp=101", {tx_line, busy, done});
        end
    endtask

    task automatic test_enable();
        logic [DW-1:0] w;
        int            bad;
        @(negedge clk);
        en = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ({tx_line, busy, done, in_ready} !== 4'b1000) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL en_low_hold got=%0d bad cycles exp=0", bad);
        end
        w = DW'($urandom);
        in_data = w; en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < LA; i++) begin
            if (i == 10) en = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({tx_line, busy, done} !== {exp_bit(w, i), 2'b10}) begin
                n_fail++; $display("FAIL en_drop word=%h cyc=%0d got=%b exp=%b", w, i, {tx_line, busy, done}, {exp_bit(w, i), 2'b10});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if ({tx_line, busy, done, in_ready} !== 4'b1010) begin
            n_fail++; $display("FAIL en_drop_done got=%b exp=1010", {tx_line, busy, done, in_ready});
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_frames();
        test_back_to_back();
        test_two_stop_bits();
        test_reset_mid_frame();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
